// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM driving the
// shared memory port, IR/PC strobes and datapath control. Traps on illegal opcode or bus timeout.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_dbg
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
  localparam logic [2:0] C_R = 3'd0, C_LD = 3'd1, C_ST = 3'd2, C_BR = 3'd3,
                         C_JAL = 3'd4, C_LUI = 3'd5, C_I = 3'd6;

  logic [2:0]       state_q, state_d, class_q, class_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout;

  // Unmasked control; every combinational output is forced low while rst is high.
  logic       req_c, we_c, sel_c, irw_c, pcw_c, rw_c, m2r_c, asrc_c, ret_c;
  logic [1:0] pcs_c, aop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      class_q <= C_R;
      wait_q  <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign timeout = req_c && !mem_ready && (wait_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin state_d = S_TRAP; cause_d = 2'b10; end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          7'b0110011: class_d = C_R;
          7'b0000011: class_d = C_LD;
          7'b0100011: class_d = C_ST;
          7'b1100011: class_d = C_BR;
          7'b1101111: class_d = C_JAL;
          7'b0110111: class_d = C_LUI;
          7'b0010011: class_d = C_I;
          default: begin state_d = S_TRAP; cause_d = 2'b01; end
        endcase
      end
      S_EXEC: begin
        case (class_q)
          C_LD, C_ST:     state_d = S_MEM;
          C_BR, C_JAL:    state_d = S_FETCH;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = (class_q == C_ST) ? S_FETCH : S_WB;
        else if (timeout) begin state_d = S_TRAP; cause_d = 2'b10; end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
    if (state_d == S_TRAP) trap_d = 1'b1;
    // Counter restarts at every ack and whenever no request is outstanding.
    wait_d = (req_c && !mem_ready) ? wait_q + TO_W'(1) : '0;
    cnt_d  = ret_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    req_c = 1'b0; we_c = 1'b0; sel_c = 1'b0; irw_c = 1'b0; pcw_c = 1'b0;
    pcs_c = 2'b00; rw_c = 1'b0; m2r_c = 1'b0; asrc_c = 1'b0; aop_c = 2'b00;
    ret_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        irw_c = mem_ready;
        pcw_c = mem_ready;
      end
      S_EXEC: begin
        case (class_q)
          C_R:     begin asrc_c = 1'b0; aop_c = 2'b10; end
          C_LD:    begin asrc_c = 1'b1; aop_c = 2'b00; end
          C_ST:    begin asrc_c = 1'b1; aop_c = 2'b01; end
          C_BR:    begin aop_c = 2'b01; pcw_c = zero; pcs_c = 2'b01; ret_c = 1'b1; end
          C_JAL:   begin rw_c = 1'b1; pcw_c = 1'b1; pcs_c = 2'b10; ret_c = 1'b1; end
          default: begin asrc_c = 1'b1; aop_c = 2'b11; end
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        sel_c  = 1'b1;
        we_c   = (class_q == C_ST);
        asrc_c = 1'b1;
        ret_c  = (class_q == C_ST) && mem_ready;
      end
      S_WB: begin
        rw_c  = 1'b1;
        m2r_c = (class_q == C_LD);
        ret_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req      = req_c  & ~rst;
  assign mem_we       = we_c   & ~rst;
  assign mem_addr_sel = sel_c  & ~rst;
  assign ir_write     = irw_c  & ~rst;
  assign pc_write     = pcw_c  & ~rst;
  assign pc_src       = pcs_c  & {2{~rst}};
  assign reg_write    = rw_c   & ~rst;
  assign mem_to_reg   = m2r_c  & ~rst;
  assign alu_src      = asrc_c & ~rst;
  assign alu_op       = aop_c  & {2{~rst}};
  assign retire       = ret_c  & ~rst;
  assign retire_count = cnt_q;
  assign trap         = trap_q;
  assign trap_cause   = cause_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle trace
// (from class, memory wait counts and zero), then replayed against the DUT cycle by cycle.
module tb_multicycle_controller;
  logic       clk, rst, zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, mem_to_reg;
  logic       alu_src, retire, trap;
  logic [1:0] pc_src, alu_op, trap_cause;
  logic [3:0] retire_count;
  logic [2:0] state_dbg;

  multicycle_controller #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .retire(retire), .retire_count(retire_count),
    .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic req, we, sel, irw, pcw; logic [1:0] pcs; logic rw, m2r, asrc;
    logic [1:0] aop; logic ret, trp; logic [1:0] cause; logic [2:0] st;
  } exp_t;
  typedef struct { logic rdy; logic [6:0] opc; logic z; exp_t e; logic [3:0] cnt; } cyc_t;

  cyc_t       q[$];
  int         cnt_m, vectors, miscompares, trap_n;
  bit         trapped;
  logic [6:0] opc_tab [7];
  logic       ex_asrc [7];
  logic [1:0] ex_aop  [7];
  logic [6:0] ill_opc;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] rnd7(); return 7'($urandom); endfunction
  function automatic logic rnd1(); return 1'($urandom); endfunction

  task automatic push(logic rdy, logic [6:0] opc, logic z, exp_t e);
    cyc_t c;
    c.rdy = rdy; c.opc = opc; c.z = z; c.e = e; c.cnt = 4'(cnt_m);
    if (e.ret) cnt_m = (cnt_m + 1) % 16;
    q.push_back(c);
  endtask

  task automatic trap_cycles(logic [1:0] cause);
    exp_t e;
    e = '0; e.trp = 1'b1; e.cause = cause; e.st = 3'd5;
    for (int i = 0; i < trap_n; i++) push(rnd1(), rnd7(), rnd1(), e);
    trapped = 1'b1;
  endtask

  // One memory access: w un-acked cycles then an ack; w>=4 exceeds the timeout of 4.
  task automatic access(int w, logic [2:0] st, logic we, logic sel, logic asrc,
                        logic ack_ret, logic ack_strobes);
    exp_t e;
    e = '0; e.req = 1'b1; e.we = we; e.sel = sel; e.asrc = asrc; e.st = st;
    for (int i = 0; i < w && i < 4; i++) push(1'b0, rnd7(), rnd1(), e);
    if (w >= 4) trap_cycles(2'b10);
    else begin
      e.irw = ack_strobes; e.pcw = ack_strobes; e.ret = ack_ret;
      push(1'b1, rnd7(), rnd1(), e);
    end
  endtask

  // cls 0..6 = R,LD,ST,BR,JAL,LUI,I ; 7 = illegal (uses ill_opc)
  task automatic instr(int cls, int fw, int mw, logic z);
    exp_t e;
    trapped = 1'b0;
    access(fw, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (trapped) return;
    e = '0; e.st = 3'd1;
    push(rnd1(), (cls < 7) ? opc_tab[cls] : ill_opc, rnd1(), e);
    if (cls == 7) begin trap_cycles(2'b01); return; end
    e = '0; e.st = 3'd2; e.asrc = ex_asrc[cls]; e.aop = ex_aop[cls];
    if (cls == 3) begin e.pcw = z; e.pcs = 2'b01; e.ret = 1'b1; end
    if (cls == 4) begin e.rw = 1'b1; e.pcw = 1'b1; e.pcs = 2'b10; e.ret = 1'b1; end
    push(rnd1(), rnd7(), z, e);
    if (cls == 1 || cls == 2) begin
      access(mw, 3'd3, cls == 2, 1'b1, 1'b1, cls == 2, 1'b0);
      if (trapped) return;
    end
    if (cls == 0 || cls == 1 || cls == 5 || cls == 6) begin
      e = '0; e.st = 3'd4; e.rw = 1'b1; e.m2r = (cls == 1); e.ret = 1'b1;
      push(rnd1(), rnd7(), rnd1(), e);
    end
  endtask

  function automatic exp_t dut_outs();
    return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
            mem_to_reg, alu_src, alu_op, retire, trap, trap_cause, state_dbg};
  endfunction

  // Entered just after a rising edge; drives a cycle, checks mid-cycle, waits an edge.
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.rdy; opcode = c.opc; zero = c.z;
      #4;
      cmp("outputs", 32'(dut_outs()), 32'(c.e));
      cmp("retire_count", 32'(retire_count), 32'(c.cnt));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    cmp("reset_outputs", 32'(dut_outs()), 32'd0);
    cmp("reset_count", 32'(retire_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_m = 0;
  endtask

  function automatic bit legal(logic [6:0] o);
    for (int i = 0; i < 7; i++) if (opc_tab[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    exp_t e;
    int cls, fw, mw;
    opc_tab = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010011};
    ex_asrc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ex_aop  = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11};
    vectors = 0; miscompares = 0; cnt_m = 0; trap_n = 5;
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    #1;
    do_reset();

    instr(0, 0, 0, 1'b0);  cmp("add_len", 32'(q.size()), 32'd4);  run_q();
    cmp("add_retired", 32'(retire_count), 32'd1);
    instr(1, 0, 3, 1'b0);  cmp("lw_len", 32'(q.size()), 32'd8);  run_q();
    instr(3, 0, 0, 1'b1);  cmp("beq_len", 32'(q.size()), 32'd3); run_q();
    instr(3, 0, 0, 1'b0);  run_q();
    instr(0, 3, 0, 1'b0);  run_q();
    cmp("directed_retired", 32'(retire_count), 32'd5);

    trap_n = 20; ill_opc = 7'b0000000;
    instr(7, 0, 0, 1'b0);  run_q();
    do_reset();
    trap_n = 5;
    instr(0, 4, 0, 1'b0);  run_q();
    do_reset();

    // Reset pulse while a store waits in MEMORY.
    access(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = '0; e.st = 3'd1; push(1'b0, opc_tab[2], 1'b0, e);
    e = '0; e.st = 3'd2; e.asrc = 1'b1; e.aop = 2'b01; push(1'b0, rnd7(), 1'b0, e);
    run_q();
    mem_ready = 1'b0;
    #1;
    cmp("sw_mem_req", 32'({mem_req, mem_we, mem_addr_sel}), 32'b111);
    do_reset();

    for (int i = 0; i < 17; i++) instr(6, 0, 0, 1'b0);
    run_q();
    cmp("count_wrap", 32'(retire_count), 32'd1);

    trap_n = 3;
    for (int n = 0; n < 80; n++) begin
      cls = ($urandom % 20 == 0) ? 7 : int'($urandom % 7);
      fw  = ($urandom % 16 == 0) ? 4 : int'($urandom % 4);
      mw  = ($urandom % 12 == 0) ? 4 + int'($urandom % 2) : int'($urandom % 4);
      do ill_opc = rnd7(); while (legal(ill_opc));
      instr(cls, fw, mw, rnd1());
      run_q();
      if (trapped) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
